serial_adder_ctrl: RTL and testbench



---
 rtl/serial_adder_ctrl_pkg.sv | 11 +
 rtl/serial_adder_ctrl_fa.sv | 16 +
 rtl/serial_adder_ctrl.sv | 112 +++++++++++
 tb/tb_serial_adder_ctrl.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/serial_adder_ctrl_pkg.sv
// Shared types and state encoding for the bit-serial adder controller.
package serial_adder_ctrl_pkg;

  // Sequencer states; encoding 2'd3 is unused and recovers to StIdle.
  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StDone = 2'd2
  } state_e;

endpackage

// File: rtl/serial_adder_ctrl_fa.sv
// Single-bit full adder cell shared by the serial adder controller.
module fa (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  // Plain combinational full adder.
  always_comb begin
    sum  = a ^ b ^ cin;
    cout = (a & b) | (a & cin) | (b & cin);
  end

endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial WIDTH-bit adder: one full adder reused LSB-first over WIDTH cycles,
// result presented with a one-cycle done pulse.
module serial_adder_ctrl
  import serial_adder_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CntW-1:0] LastBit = CntW'(WIDTH - 1);

  state_e            state_q, state_d;
  logic [WIDTH-1:0]  a_sh_q, b_sh_q, res_sh_q;
  logic [CntW-1:0]   cnt_q;
  logic              carry_q;
  logic [WIDTH-1:0]  sum_q;
  logic              cout_q, ovf_q;
  logic              fa_sum, fa_cout;
  logic              last_bit;

  assign last_bit = (cnt_q == LastBit);

  fa u_fa (
    .a    (a_sh_q[0]),
    .b    (b_sh_q[0]),
    .cin  (carry_q),
    .sum  (fa_sum),
    .cout (fa_cout)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state: start only honoured in idle, done always returns to idle.
  always_comb begin
    state_d = StIdle;
    case (state_q)
      StIdle:  state_d = start ? StRun : StIdle;
      StRun:   state_d = last_bit ? StDone : StRun;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Outputs decoded from state; result registers drive the data outputs.
  always_comb begin
    busy = (state_q == StRun);
    done = (state_q == StDone);
    sum  = sum_q;
    cout = cout_q;
    ovf  = ovf_q;
  end

  // Datapath: operand capture, per-bit shifting, and result publication on the last bit.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_sh_q   <= '0;
      b_sh_q   <= '0;
      res_sh_q <= '0;
      cnt_q    <= '0;
      carry_q  <= 1'b0;
      sum_q    <= '0;
      cout_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          if (start) begin
            a_sh_q  <= a;
            b_sh_q  <= b;
            carry_q <= cin;
            cnt_q   <= '0;
          end
        end
        StRun: begin
          a_sh_q   <= a_sh_q >> 1;
          b_sh_q   <= b_sh_q >> 1;
          res_sh_q <= {fa_sum, res_sh_q[WIDTH-1:1]};
          carry_q  <= fa_cout;
          if (last_bit) begin
            // carry_q here is the carry into the MSB.
            sum_q  <= {fa_sum, res_sh_q[WIDTH-1:1]};
            cout_q <= fa_cout;
            ovf_q  <= carry_q ^ fa_cout;
          end else begin
            cnt_q <= cnt_q + CntW'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Self-checking bench for serial_adder_ctrl against an arithmetic reference model.
module tb_serial_adder_ctrl;

  localparam int unsigned W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] a, b;
  logic         cin;
  logic         busy, done, cout, ovf;
  logic [W-1:0] sum;

  int nvec = 0;
  int nerr = 0;

  serial_adder_ctrl #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .cin   (cin),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout),
    .ovf   (ovf)
  );

  always #5 clk = ~clk;

  // Reference: {ovf, cout, sum} from plain integer addition and signed-overflow rule.
  function automatic logic [W+1:0] model(input logic [W-1:0] x, input logic [W-1:0] y,
                                         input logic c);
    logic [W:0] t;
    logic       v;
    t = {1'b0, x} + {1'b0, y} + {{W{1'b0}}, c};
    v = (x[W-1] == y[W-1]) && (t[W-1] != x[W-1]);
    return {v, t};
  endfunction

  // Drives one operation from idle; reports edges to done, busy cycles, result
  // stability during the run, and whether done dropped after one cycle.
  task automatic do_op(input logic [W-1:0] oa, input logic [W-1:0] ob, input logic oc,
                       input bit noise, output int edges, output int bcnt,
                       output bit held, output logic done_after);
    logic [W+1:0] prev;
    @(negedge clk);
    a = oa; b = ob; cin = oc; start = 1'b1;
    prev = {ovf, cout, sum};
    @(posedge clk); #1;
    start = 1'b0;
    a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
    edges = 0; bcnt = 0; held = 1'b1;
    while (done !== 1'b1 && edges < 40) begin
      if (busy === 1'b1) bcnt++;
      if ({ovf, cout, sum} !== prev) held = 1'b0;
      start = (noise && edges == 3) ? 1'b1 : 1'b0;
      @(posedge clk); #1;
      edges++;
    end
    start = 1'b0;
    @(posedge clk); #1;
    done_after = done;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; a = '0; b = '0; cin = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    nvec++;
    if ({busy, done, sum, cout, ovf} !== '0) begin
      nerr++;
      $display("FAIL reset_outputs: got busy=%b done=%b sum=%h cout=%b ovf=%b, want all 0",
               busy, done, sum, cout, ovf);
    end
    rst = 1'b0;
  endtask

  // One operation with full result, latency and busy-width checks.
  task automatic check_op(input string name, input logic [W-1:0] oa, input logic [W-1:0] ob,
                          input logic oc, input bit noise);
    int e, bc;
    bit h;
    logic da;
    logic [W+1:0] exp;
    logic [W+1:0] got;
    exp = model(oa, ob, oc);
    do_op(oa, ob, oc, noise, e, bc, h, da);
    // Results remain latched after done drops.
    got = {ovf, cout, sum};
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s result a=%h b=%h cin=%b: got ovf=%b cout=%b sum=%h, want ovf=%b cout=%b sum=%h",
               name, oa, ob, oc, got[W+1], got[W], got[W-1:0], exp[W+1], exp[W], exp[W-1:0]);
    end
    nvec++;
    if (e !== W) begin
      nerr++;
      $display("FAIL %s latency: got %0d edges after accept, want %0d", name, e, W);
    end
    nvec++;
    if (bc !== W) begin
      nerr++;
      $display("FAIL %s busy_cycles: got %0d, want %0d", name, bc, W);
    end
    nvec++;
    if (h !== 1'b1) begin
      nerr++;
      $display("FAIL %s result_held_during_run: got %b, want 1", name, h);
    end
    nvec++;
    if (da !== 1'b0) begin
      nerr++;
      $display("FAIL %s done_one_cycle: done after pulse got %b, want 0", name, da);
    end
  endtask

  task automatic test_directed();
    check_op("inc",       8'h01, 8'h00, 1'b0, 1'b0);
    check_op("wrap",      8'hFF, 8'h01, 1'b0, 1'b0);
    check_op("pos_ovf",   8'h7F, 8'h01, 1'b0, 1'b0);
    check_op("neg_ovf",   8'h80, 8'h80, 1'b0, 1'b0);
    check_op("cin_carry", 8'hA5, 8'h5A, 1'b1, 1'b0);
  endtask

  task automatic test_random();
    for (int i = 0; i < 30; i++) begin
      check_op("random", W'($urandom), W'($urandom), 1'($urandom), 1'b0);
    end
  endtask

  task automatic test_start_ignored();
    for (int i = 0; i < 4; i++) begin
      check_op("start_in_run", W'($urandom), W'($urandom), 1'($urandom), 1'b1);
    end
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] x1, y1, x2, y2;
    logic c1, c2;
    logic [W+1:0] exp;
    int n;
    x1 = W'($urandom); y1 = W'($urandom); c1 = 1'($urandom);
    x2 = W'($urandom); y2 = W'($urandom); c2 = 1'($urandom);
    @(negedge clk);
    a = x1; b = y1; cin = c1; start = 1'b1;
    @(posedge clk); #1;
    n = 0;
    while (done !== 1'b1 && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    a = x2; b = y2; cin = c2;
    exp = model(x1, y1, c1);
    nvec++;
    if ({ovf, cout, sum} !== exp) begin
      nerr++;
      $display("FAIL b2b_first: got %h, want %h", {ovf, cout, sum}, exp);
    end
    @(posedge clk); #1;
    nvec++;
    if (busy !== 1'b0) begin
      nerr++;
      $display("FAIL b2b_idle_gap: busy got %b, want 0", busy);
    end
    @(posedge clk); #1;
    nvec++;
    if (busy !== 1'b1) begin
      nerr++;
      $display("FAIL b2b_reaccept: busy got %b, want 1", busy);
    end
    n = 0;
    while (done !== 1'b1 && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    start = 1'b0;
    exp = model(x2, y2, c2);
    nvec++;
    if ({ovf, cout, sum} !== exp || n !== W) begin
      nerr++;
      $display("FAIL b2b_second: got %h after %0d edges, want %h after %0d", {ovf, cout, sum},
               n, exp, W);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_abort();
    bit saw_done;
    // Leave a nonzero result latched so the reset clear is observable.
    check_op("pre_abort", 8'h7F, 8'h01, 1'b0, 1'b0);
    @(negedge clk);
    a = 8'h12; b = 8'h34; cin = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    nvec++;
    if ({busy, done, sum, cout, ovf} !== '0) begin
      nerr++;
      $display("FAIL reset_abort_outputs: got busy=%b done=%b sum=%h cout=%b ovf=%b, want all 0",
               busy, done, sum, cout, ovf);
    end
    saw_done = 1'b0;
    repeat (W + 4) begin
      @(posedge clk); #1;
      if (done === 1'b1 || busy === 1'b1) saw_done = 1'b1;
    end
    nvec++;
    if (saw_done !== 1'b0) begin
      nerr++;
      $display("FAIL reset_abort_no_done: got activity=%b, want 0", saw_done);
    end
    check_op("post_abort", 8'h3C, 8'hC3, 1'b1, 1'b0);
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_start_ignored();
    test_back_to_back();
    test_reset_abort();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
